// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the matrix-multiply load sequencer.
// Purely declarative: no logic, no latency.
// Sizing keeps beat counts wide enough that the dimension products never truncate.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    COMPUTE = 3'd3,
    DONE    = 3'd4
  } sched_state_t;

  localparam int DEF_N1  = 4;
  localparam int DEF_N2  = 4;
  localparam int DEF_MSW = 16;

  // Width of a beat count: blocks * N * inner dimension, with N bounded by max(N1,N2).
  function automatic int beats_width(input int msw, input int n1, input int n2);
    int nmax;
    nmax = (n1 > n2) ? n1 : n2;
    return 2 * msw + $clog2(nmax);
  endfunction

  localparam int BEATS_W = beats_width(DEF_MSW, DEF_N1, DEF_N2);

endpackage

// File: rtl/matmul_load_sched_beat_counter.sv
// Beat counter shared by the A and B load phases: load a terminal value, count beats.
// Registered count; tc_o is combinational from the count and the loaded terminal value.
// No backpressure of its own; advances only when inc_i is asserted.
module beat_counter #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic         tc_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] term_q, term_d;

  // Load takes priority (new phase), then clear (phase end), then count a beat.
  always_comb begin
    cnt_d  = cnt_q;
    term_d = term_q;
    if (load_i) begin
      term_d = load_val_i;
      cnt_d  = '0;
    end else if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Count and terminal value registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      term_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      term_q <= term_d;
    end
  end

  assign tc_o = (cnt_q == term_q - ONE);

endmodule

// File: rtl/matmul_load_sched.sv
// Job sequencer: steers one input stream into the A then B write paths, then runs compute.
// Stream data passes to wr_data with zero latency; compute_start is registered (first COMPUTE cycle).
// s_ready is high only in LOAD_A/LOAD_B; s_valid gaps simply stall. Perf counters: MATMUL_SCHED_PERF_EN.
module matmul_load_sched
  import matmul_pkg::*;
#(
  parameter int N1           = 4,
  parameter int N2           = 4,
  parameter int MATRIXSIZE_W = 16,
  parameter int DATA_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [MATRIXSIZE_W-1:0] M1dN1,
  input  logic [MATRIXSIZE_W-1:0] M2,
  input  logic [MATRIXSIZE_W-1:0] M3dN2,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_W-1:0]       s_data,
  output logic                    valid_A,
  output logic                    valid_B,
  output logic [DATA_W-1:0]       wr_data,
  output logic                    compute_start,
  input  logic                    compute_done,
  output logic                    busy,
  output logic                    done,
  output logic                    err_cfg,
  output logic [31:0]             perf_cycles,
  output logic [31:0]             perf_stalls
);

  localparam int BW = beats_width(MATRIXSIZE_W, N1, N2);
  localparam logic [BW-1:0] N1_W = BW'(N1);
  localparam logic [BW-1:0] N2_W = BW'(N2);

  sched_state_t state_q, state_d;

  logic [MATRIXSIZE_W-1:0] m2_q, m3_q;
  logic                    err_q;
  logic                    cs_q;

  logic          accept, dim_zero, in_load, beat, last_beat;
  logic [BW-1:0] beats_a, beats_b;
  logic          cnt_load, cnt_clr;
  logic [BW-1:0] cnt_load_val;

  assign accept   = (state_q == IDLE) && start;
  assign dim_zero = (M1dN1 == '0) || (M2 == '0) || (M3dN2 == '0);
  assign in_load  = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign beat     = in_load && s_valid;

  // A count comes from the live inputs at start; B count from the dimensions latched then.
  assign beats_a = BW'(M1dN1) * N1_W * BW'(M2);
  assign beats_b = BW'(m3_q) * N2_W * BW'(m2_q);

  assign cnt_load     = (accept && !dim_zero) || ((state_q == LOAD_A) && beat && last_beat);
  assign cnt_load_val = accept ? beats_a : beats_b;
  assign cnt_clr      = (state_q == LOAD_B) && beat && last_beat;

  beat_counter #(.W(BW)) u_beat_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .clr_i      (cnt_clr),
    .inc_i      (beat),
    .tc_o       (last_beat)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic: a zero dimension skips straight to DONE with no load beats.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = dim_zero ? DONE : LOAD_A;
      LOAD_A:  if (beat && last_beat) state_d = LOAD_B;
      LOAD_B:  if (beat && last_beat) state_d = COMPUTE;
      COMPUTE: if (compute_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs; write data is forced to zero outside the load phases.
  always_comb begin
    s_ready = in_load;
    valid_A = (state_q == LOAD_A) && s_valid;
    valid_B = (state_q == LOAD_B) && s_valid;
    wr_data = in_load ? s_data : '0;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
  end

  // Dimension latch, config-error flag and the registered compute_start pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      m2_q  <= '0;
      m3_q  <= '0;
      err_q <= 1'b0;
      cs_q  <= 1'b0;
    end else begin
      if (accept) begin
        m2_q  <= M2;
        m3_q  <= M3dN2;
        err_q <= dim_zero;
      end
      cs_q <= (state_d == COMPUTE) && (state_q != COMPUTE);
    end
  end

  assign err_cfg       = err_q;
  assign compute_start = cs_q;

`ifdef MATMUL_SCHED_PERF_EN
  logic [31:0] cyc_q, stl_q;

  // Job cycle and load-stall counters; the start cycle counts as cycle 1, values hold in IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc_q <= '0;
      stl_q <= '0;
    end else if (accept) begin
      cyc_q <= 32'd1;
      stl_q <= '0;
    end else begin
      if ((state_q != IDLE) && (cyc_q != 32'hFFFF_FFFF)) cyc_q <= cyc_q + 32'd1;
      if (in_load && !s_valid && (stl_q != 32'hFFFF_FFFF)) stl_q <= stl_q + 32'd1;
    end
  end

  assign perf_cycles = cyc_q;
  assign perf_stalls = stl_q;
`else
  assign perf_cycles = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_matmul_load_sched.sv
// Directed bench for matmul_load_sched with a strobe/data scoreboard.
// Inputs are driven at the falling edge; outputs are sampled 1ns later, before the next rising edge.
module tb_matmul_load_sched;

  localparam int MSW = 16;
  localparam int DW  = 32;

  logic           clk = 1'b0;
  logic           rst, start, s_valid, compute_done;
  logic [MSW-1:0] M1dN1, M2, M3dN2;
  logic [DW-1:0]  s_data;
  logic           s_ready, valid_A, valid_B, compute_start, busy, done, err_cfg;
  logic [DW-1:0]  wr_data;
  logic [31:0]    perf_cycles, perf_stalls;

  always #5 clk = ~clk;

  matmul_load_sched #(.N1(4), .N2(4), .MATRIXSIZE_W(MSW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .M1dN1(M1dN1), .M2(M2), .M3dN2(M3dN2),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .valid_A(valid_A), .valid_B(valid_B), .wr_data(wr_data),
    .compute_start(compute_start), .compute_done(compute_done),
    .busy(busy), .done(done), .err_cfg(err_cfg),
    .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
  );

  typedef struct packed {
    logic        is_a;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;
  int step_no = 0;
  int na = 0, nb = 0, ncs = 0;
  int start_step, done_step, stalls;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop the scoreboard on every strobe and compare phase and data.
  task automatic monitor();
    exp_t e;
    if (valid_A || valid_B) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_strobe", 64'(step_no), 64'(-1));
      end else begin
        e = sb_q.pop_front();
        chk("strobe_phase", {62'd0, valid_A, valid_B}, e.is_a ? 64'd2 : 64'd1);
        chk("wr_data", 64'(wr_data), 64'(e.data));
      end
      if (valid_A) na++;
      if (valid_B) nb++;
    end
    if (compute_start) ncs++;
  endtask

  task automatic step(input logic sv, input logic [31:0] sd, input logic st, input logic cd);
    @(negedge clk);
    s_valid = sv; s_data = sd; start = st; compute_done = cd;
    step_no++;
    #1;
    monitor();
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_s_ready"}, 64'(s_ready), 64'd0);
    chk({pfx, "_valid_A"}, 64'(valid_A), 64'd0);
    chk({pfx, "_valid_B"}, 64'(valid_B), 64'd0);
    chk({pfx, "_wr_data"}, 64'(wr_data), 64'd0);
    chk({pfx, "_compute_start"}, 64'(compute_start), 64'd0);
    chk({pfx, "_busy"}, 64'(busy), 64'd0);
    chk({pfx, "_done"}, 64'(done), 64'd0);
    chk({pfx, "_err_cfg"}, 64'(err_cfg), 64'd0);
    chk({pfx, "_perf_cycles"}, 64'(perf_cycles), 64'd0);
    chk({pfx, "_perf_stalls"}, 64'(perf_stalls), 64'd0);
  endtask

  task automatic issue_start(input int m1, input int m2, input int m3);
    M1dN1 = MSW'(m1); M2 = MSW'(m2); M3dN2 = MSW'(m3);
    na = 0; nb = 0; stalls = 0;
    step(1'b0, 32'd0, 1'b1, 1'b0);
    start_step = step_no;
    chk("idle_at_start", 64'(busy), 64'd0);
  endtask

  // Feed nA+nB beats; optional every-other-cycle gaps; optional start pulse on beat index poke.
  task automatic load_stream(input int n_a, input int n_b, input bit toggle, input int base, input int poke);
    int k = 0;
    int cyc = 0;
    while (k < n_a + n_b) begin
      if (toggle && (cyc % 2 == 1)) begin
        step(1'b0, 32'hDEAD_0000 | 32'(k), 1'b0, 1'b0);
        chk("s_ready_gap", 64'(s_ready), 64'd1);
        chk("gap_no_strobe", {62'd0, valid_A, valid_B}, 64'd0);
        stalls++;
      end else begin
        sb_q.push_back('{is_a: (k < n_a), data: 32'(base + k)});
        step(1'b1, 32'(base + k), (k == poke), 1'b0);
        chk("s_ready_beat", 64'(s_ready), 64'd1);
        k++;
      end
      cyc++;
    end
  endtask

  // Compute phase: compute_done lat cycles after compute_start, then expect done and idle.
  task automatic run_tail(input int lat, input bit poke, input int exp_a, input int exp_b);
    step(1'b0, 32'd0, poke, (lat == 0));
    chk("compute_start_first", 64'(compute_start), 64'd1);
    chk("no_ready_compute", 64'(s_ready), 64'd0);
    for (int i = 1; i <= lat; i++) begin
      step(1'b0, 32'd0, poke, (i == lat));
      chk("compute_start_once", 64'(compute_start), 64'd0);
      chk("no_done_early", 64'(done), 64'd0);
    end
    step(1'b0, 32'd0, 1'b0, 1'b0);
    done_step = step_no;
    chk("done_pulse", 64'(done), 64'd1);
    chk("busy_in_done", 64'(busy), 64'd1);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("idle_after_done", 64'(busy), 64'd0);
    chk("count_A", 64'(na), 64'(exp_a));
    chk("count_B", 64'(nb), 64'(exp_b));
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
`ifdef MATMUL_SCHED_PERF_EN
    chk("perf_cycles", 64'(perf_cycles), 64'(done_step - start_step + 1));
    chk("perf_stalls", 64'(perf_stalls), 64'(stalls));
`else
    chk("perf_cycles_tied", 64'(perf_cycles), 64'd0);
    chk("perf_stalls_tied", 64'(perf_stalls), 64'd0);
`endif
    step(1'b0, 32'd0, 1'b0, 1'b0);
    chk("stay_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    int cs0;
    rst = 1'b0; start = 1'b0; s_valid = 1'b0; compute_done = 1'b0; s_data = '0;
    M1dN1 = '0; M2 = '0; M3dN2 = '0;

    // Reset state.
    repeat (3) step(1'b0, 32'd0, 1'b0, 1'b0);
    chk_all_zero("reset");
    rst = 1'b1;
    step(1'b0, 32'd0, 1'b0, 1'b0);

    // Zero inner dimension: rejected straight to DONE.
    cs0 = ncs;
    issue_start(1, 0, 1);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    done_step = step_no;
    chk("err_done", 64'(done), 64'd1);
    chk("err_flag", 64'(err_cfg), 64'd1);
    chk("err_no_ready", 64'(s_ready), 64'd0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    chk("err_done_once", 64'(done), 64'd0);
    chk("err_idle", 64'(busy), 64'd0);
    chk("err_flag_hold", 64'(err_cfg), 64'd1);
    chk("err_no_compute", 64'(ncs - cs0), 64'd0);
`ifdef MATMUL_SCHED_PERF_EN
    chk("err_perf_cycles", 64'(perf_cycles), 64'(done_step - start_step + 1));
`endif

    // Continuous stream, 8 A + 8 B beats, compute_done 5 cycles after compute_start.
    issue_start(1, 2, 1);
    load_stream(8, 8, 1'b0, 32'h100, -1);
    chk("err_cleared", 64'(err_cfg), 64'd0);
    run_tail(5, 1'b0, 8, 8);

    // Toggling s_valid: same strobe counts, order preserved, stalls counted.
    issue_start(1, 2, 1);
    load_stream(8, 8, 1'b1, 32'h200, -1);
    run_tail(3, 1'b0, 8, 8);

    // start pulses during LOAD_B and COMPUTE are ignored; compute_done with compute_start.
    issue_start(1, 2, 1);
    load_stream(8, 8, 1'b0, 32'h300, 10);
    run_tail(0, 1'b1, 8, 8);

    // Reset during LOAD_B beat 3, then a fresh 8 A + 4 B job.
    issue_start(1, 2, 1);
    load_stream(8, 3, 1'b0, 32'h400, -1);
    @(negedge clk);
    rst = 1'b0; s_valid = 1'b1; s_data = 32'h4FF; start = 1'b0; compute_done = 1'b0;
    step_no++;
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0; s_data = '0;
    step_no++;
    #1;
    chk_all_zero("midjob_reset");
    chk("reset_sb", 64'(sb_q.size()), 64'd0);
    issue_start(2, 1, 1);
    load_stream(8, 4, 1'b0, 32'h500, -1);
    run_tail(2, 1'b0, 8, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at step %0d", step_no);
    $fatal(1, "watchdog");
  end

endmodule
